// File: rtl/uart_result_tx_if.sv
// Handshake/serial bundle for the result transmitter.
//   send      : request pulse from the network's completion event
//   digit     : 4-bit argmax result, sampled when send is accepted
//   tx_serial : UART line, idle high
//   busy      : packet in flight
//   done      : one-cycle pulse at the end of the last stop bit
// master = requester side, slave = transmitter side.
interface uart_result_tx_if;
    logic       send;
    logic [3:0] digit;
    logic       tx_serial;
    logic       busy;
    logic       done;

    modport master (output send, output digit, input tx_serial, input busy, input done);
    modport slave  (input send, input digit, output tx_serial, output busy, output done);
endinterface

// File: rtl/uart_result_tx.sv
// Serial result transmitter: on an accepted send pulse, latches the digit and
// sends a 3-byte packet {0xA5, ASCII digit or '?', XOR checksum} as 8N1 UART,
// LSB first, with no gap between bytes.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; forces the line high at once
//   io    : uart_result_tx_if.slave (send, digit in; tx_serial, busy, done out)
// All outputs are registered; there is no combinational input-to-output path.
module uart_result_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic           clk,
    input  logic           reset,
    uart_result_tx_if.slave io
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [1:0]       byte_idx;
    logic [2:0]       bit_idx;
    logic [3:0]       digit_q;

    logic [7:0] ascii_byte;
    logic [7:0] cur_byte;
    logic       slot_end;

    always_comb begin
        ascii_byte = (digit_q <= 4'd9) ? (8'h30 + {4'd0, digit_q}) : 8'h3F;
        case (byte_idx)
            2'd0:    cur_byte = 8'hA5;
            2'd1:    cur_byte = ascii_byte;
            default: cur_byte = 8'hA5 ^ ascii_byte;
        endcase
        slot_end = (baud_cnt == CNT_MAX);
    end

    // Each transition loads tx_serial with the level of the slot being
    // entered, so the line changes on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            byte_idx     <= '0;
            bit_idx      <= '0;
            digit_q      <= '0;
            io.tx_serial <= 1'b1;
            io.busy      <= 1'b0;
            io.done      <= 1'b0;
        end else begin
            io.done <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (io.send) begin
                        digit_q      <= io.digit;
                        byte_idx     <= 2'd0;
                        bit_idx      <= 3'd0;
                        state        <= START;
                        io.tx_serial <= 1'b0;
                        io.busy      <= 1'b1;
                    end
                end
                START: begin
                    if (slot_end) begin
                        baud_cnt     <= '0;
                        bit_idx      <= 3'd0;
                        state        <= DATA;
                        io.tx_serial <= cur_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (slot_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state        <= STOP;
                            io.tx_serial <= 1'b1;
                        end else begin
                            bit_idx      <= bit_idx + 3'd1;
                            io.tx_serial <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (slot_end) begin
                        baud_cnt <= '0;
                        if (byte_idx != 2'd2) begin
                            byte_idx     <= byte_idx + 2'd1;
                            state        <= START;
                            io.tx_serial <= 1'b0;
                        end else begin
                            // busy drops with done, so a send in this cycle
                            // is accepted on the next edge.
                            state        <= IDLE;
                            io.busy      <= 1'b0;
                            io.done      <= 1'b1;
                            io.tx_serial <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
